// File: rtl/q_max_selector_pkg.sv
// Shared constants and helpers for the Q-learning accelerator: action-width
// derivations and the exploration LFSR used by the selector.
package q_max_selector_pkg;

  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int a_dur_width(input int l_width);
    return l_width / 2;
  endfunction

  function automatic int a_width(input int l_width);
    return 2 + a_dur_width(l_width);
  endfunction

  function automatic int n_level(input int l_width);
    return 1 << a_dur_width(l_width);
  endfunction

  function automatic int n_entry(input int l_width);
    return 4 * n_level(l_width);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/q_max_selector_cmp2.sv
// Registered two-input signed compare-select cell of the argmax tree.
// On equal values the a-side (lower index) operand is kept.
module q_cmp2 #(
  parameter int Q_WIDTH = 16,
  parameter int A_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [Q_WIDTH-1:0] a_val_i,
  input  logic        [A_WIDTH-1:0] a_idx_i,
  input  logic                      a_vld_i,
  input  logic signed [Q_WIDTH-1:0] b_val_i,
  input  logic        [A_WIDTH-1:0] b_idx_i,
  input  logic                      b_vld_i,
  output logic signed [Q_WIDTH-1:0] y_val_o,
  output logic        [A_WIDTH-1:0] y_idx_o,
  output logic                      y_vld_o
);

  logic signed [Q_WIDTH-1:0] val_d, val_q;
  logic        [A_WIDTH-1:0] idx_d, idx_q;
  logic                      vld_q;
  logic                      take_b;

  always_comb begin
    take_b = (b_val_i > a_val_i);
    val_d  = take_b ? b_val_i : a_val_i;
    idx_d  = take_b ? b_idx_i : a_idx_i;
  end

  // Data only moves with a valid word so the tree root holds its last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      val_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= a_vld_i & b_vld_i;
      if (a_vld_i) begin
        val_q <= val_d;
        idx_q <= idx_d;
      end
    end
  end

  assign y_val_o = val_q;
  assign y_idx_o = idx_q;
  assign y_vld_o = vld_q;

endmodule

// File: rtl/q_max_selector.sv
// Finds the maximum Q value and its {road, level} action over one state's
// Q-table read, and produces an epsilon-greedy action from a free-running LFSR.
module q_max_selector
  import q_max_selector_pkg::*;
#(
  parameter int          L_WIDTH   = 4,
  parameter int          Q_WIDTH   = 16,
  parameter int          EPS_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [Q_WIDTH*n_level(L_WIDTH)-1:0]   D_road0,
  input  logic [Q_WIDTH*n_level(L_WIDTH)-1:0]   D_road1,
  input  logic [Q_WIDTH*n_level(L_WIDTH)-1:0]   D_road2,
  input  logic [Q_WIDTH*n_level(L_WIDTH)-1:0]   D_road3,
  input  logic [EPS_WIDTH-1:0]                  eps,
  output logic                                  out_valid,
  output logic [Q_WIDTH-1:0]                    Q_max,
  output logic [a_width(L_WIDTH)-1:0]           A_max,
  output logic [a_width(L_WIDTH)-1:0]           A_sel,
  output logic                                  explore
);

  localparam int A_WIDTH = a_width(L_WIDTH);
  localparam int N_ENTRY = n_entry(L_WIDTH);
  localparam int N_NODE  = 2 * N_ENTRY - 1;

  // Road r, level i lands at entry k = r*N_LEVEL + i, i.e. k = {road, level}.
  logic [Q_WIDTH*N_ENTRY-1:0] d_all;
  assign d_all = {D_road3, D_road2, D_road1, D_road0};

  logic signed [Q_WIDTH-1:0] in_val_q [N_ENTRY];
  logic        [A_WIDTH-1:0] in_idx_q [N_ENTRY];
  logic                      in_vld_q;
  logic [15:0]               lfsr_q;
  logic [A_WIDTH:0]          exp_q;
  logic [A_WIDTH-1:0]        rnd_q [A_WIDTH+1];

  // Input stage: capture all (value, index) pairs and the exploration sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      exp_q[0] <= 1'b0;
      rnd_q[0] <= '0;
      for (int k = 0; k < N_ENTRY; k++) begin
        in_val_q[k] <= '0;
        in_idx_q[k] <= '0;
      end
    end else begin
      in_vld_q <= in_valid;
      lfsr_q   <= lfsr_next(lfsr_q);
      if (in_valid) begin
        exp_q[0] <= (lfsr_q[EPS_WIDTH-1:0] < eps);
        rnd_q[0] <= lfsr_q[15 -: A_WIDTH];
        for (int k = 0; k < N_ENTRY; k++) begin
          in_val_q[k] <= d_all[Q_WIDTH*k +: Q_WIDTH];
          in_idx_q[k] <= A_WIDTH'(k);
        end
      end
    end
  end

  // Heap-ordered tree: node n has children 2n+1 (lower indices) and 2n+2.
  logic signed [Q_WIDTH-1:0] node_val [N_NODE];
  logic        [A_WIDTH-1:0] node_idx [N_NODE];
  logic                      node_vld [N_NODE];

  for (genvar k = 0; k < N_ENTRY; k++) begin : g_leaf
    assign node_val[N_ENTRY-1+k] = in_val_q[k];
    assign node_idx[N_ENTRY-1+k] = in_idx_q[k];
    assign node_vld[N_ENTRY-1+k] = in_vld_q;
  end

  for (genvar n = 0; n < N_ENTRY - 1; n++) begin : g_cell
    q_cmp2 #(
      .Q_WIDTH (Q_WIDTH),
      .A_WIDTH (A_WIDTH)
    ) u_cmp (
      .clk     (clk),
      .rst     (rst),
      .a_val_i (node_val[2*n+1]),
      .a_idx_i (node_idx[2*n+1]),
      .a_vld_i (node_vld[2*n+1]),
      .b_val_i (node_val[2*n+2]),
      .b_idx_i (node_idx[2*n+2]),
      .b_vld_i (node_vld[2*n+2]),
      .y_val_o (node_val[n]),
      .y_idx_o (node_idx[n]),
      .y_vld_o (node_vld[n])
    );
  end

  // Valid of tree stage s is the leftmost node at depth A_WIDTH-s.
  logic [A_WIDTH:0] stage_vld;
  for (genvar s = 0; s <= A_WIDTH; s++) begin : g_stage_vld
    assign stage_vld[s] = node_vld[(1 << (A_WIDTH - s)) - 1];
  end

  // Tree stages: sideband follows its vector one level per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= A_WIDTH; s++) begin
        exp_q[s] <= 1'b0;
        rnd_q[s] <= '0;
      end
    end else begin
      for (int s = 1; s <= A_WIDTH; s++) begin
        if (stage_vld[s-1]) begin
          exp_q[s] <= exp_q[s-1];
          rnd_q[s] <= rnd_q[s-1];
        end
      end
    end
  end

  assign out_valid = node_vld[0];
  assign Q_max     = node_val[0];
  assign A_max     = node_idx[0];
  assign explore   = exp_q[A_WIDTH];
  assign A_sel     = exp_q[A_WIDTH] ? rnd_q[A_WIDTH] : node_idx[0];

endmodule
